uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide transmit FIFO feeding an 8-bit, LSB-first UART serialiser.
// Frame: start(0), d0..d7, [even parity], stop(1); each bit CLKS_PER_BIT clocks.
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit
// (11-bit frame). Without it the PARITY state does not exist (10-bit frame).
// Reset: resetb, synchronous, active low.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        resetb,
    input  logic [7:0]                  data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CTR_W = $clog2(CLKS_PER_BIT);

    localparam logic [CTR_W-1:0] BIT_LAST = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         data_q, data_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];

    logic               bit_done;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [2:0]         bit_next;
    logic [7:0]         fifo_head;

    assign bit_done   = (cnt_q == BIT_LAST);
    assign fifo_empty = (fifo_count_q == '0);
    assign ready_o    = (fifo_count_q < DEPTH_C);
    assign push       = valid_i && ready_o;
    assign bit_next   = bit_idx_q + 3'd1;
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE) || !fifo_empty;
    assign fifo_count_o = fifo_count_q;

    // State register: all control flops, synchronously cleared by resetb.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!resetb) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            tx_q         <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            tx_q         <= tx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage: written on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
        if (resetb && push) begin
            fifo_mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Next-state logic: frame sequencing, START re-entered from STOP for back-to-back frames.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = START;
            START:  if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            STOP:   if (bit_done) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: bit timing, line level, FIFO pop/push bookkeeping.
    always_comb begin
        pop       = (state_d == START) && ((state_q == IDLE) || (state_q == STOP));
        cnt_d     = (state_q == IDLE || bit_done) ? '0 : cnt_q + CTR_W'(1);
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                bit_idx_d = '0;
            end
            START: begin
                if (bit_done) begin
                    tx_d      = data_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d = ^data_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_next;
                        tx_d      = data_q[bit_next];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) tx_d = 1'b1;
`endif
            STOP: if (bit_done) tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        // A pop loads the head byte and starts the start bit on the same edge.
        if (pop) begin
            data_d = fifo_head;
            tx_d   = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

endmodule
